// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, WB-to-ID bypass,
// bubble insertion on flush/hazard, memory-stall freeze and a saturating bubble counter.
module id_ex_hazard_reg #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_write_reg,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [3:0]        id_alu_op,
  input  logic              id_alu_src,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              wb_reg_write,
  input  logic [REG_AW-1:0] wb_write_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              branch_flush,
  input  logic              ext_stall,
  output logic              id_ex_valid,
  output logic              id_ex_reg_write,
  output logic              id_ex_mem_read,
  output logic              id_ex_mem_write,
  output logic              id_ex_mem_to_reg,
  output logic              id_ex_alu_src,
  output logic [REG_AW-1:0] id_ex_rs,
  output logic [REG_AW-1:0] id_ex_rt,
  output logic [REG_AW-1:0] id_ex_write_reg,
  output logic [DATA_W-1:0] id_ex_rs_data,
  output logic [DATA_W-1:0] id_ex_rt_data,
  output logic [DATA_W-1:0] id_ex_imm,
  output logic [3:0]        id_ex_alu_op,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              load_use_stall,
  output logic [CNT_W-1:0]  stall_cycles
);

  logic              rs_hit;
  logic              rt_hit;
  logic              wb_live;
  logic [DATA_W-1:0] rs_data_byp;
  logic [DATA_W-1:0] rt_data_byp;

  always_comb begin
    rs_hit = id_uses_rs && (id_rs == id_ex_write_reg);
    rt_hit = id_uses_rt && (id_rt == id_ex_write_reg);
    // A taken branch kills the ID instruction, so its dependency is irrelevant.
    load_use_stall = id_valid && id_ex_valid && id_ex_mem_read
                     && (id_ex_write_reg != '0) && (rs_hit || rt_hit)
                     && !branch_flush;
    pc_write_en    = !(ext_stall || load_use_stall);
    if_id_write_en = !(ext_stall || load_use_stall);
  end

  always_comb begin
    wb_live     = wb_reg_write && (wb_write_reg != '0);
    rs_data_byp = (wb_live && (wb_write_reg == id_rs)) ? wb_data : id_rs_data;
    rt_data_byp = (wb_live && (wb_write_reg == id_rt)) ? wb_data : id_rt_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_ex_valid      <= 1'b0;
      id_ex_reg_write  <= 1'b0;
      id_ex_mem_read   <= 1'b0;
      id_ex_mem_write  <= 1'b0;
      id_ex_mem_to_reg <= 1'b0;
      id_ex_alu_src    <= 1'b0;
      id_ex_rs         <= '0;
      id_ex_rt         <= '0;
      id_ex_write_reg  <= '0;
      id_ex_rs_data    <= '0;
      id_ex_rt_data    <= '0;
      id_ex_imm        <= '0;
      id_ex_alu_op     <= '0;
      stall_cycles     <= '0;
    end else if (ext_stall) begin
      // Freeze everything, including a pending flush; EX re-asserts it afterwards.
    end else if (branch_flush || load_use_stall) begin
      id_ex_valid      <= 1'b0;
      id_ex_reg_write  <= 1'b0;
      id_ex_mem_read   <= 1'b0;
      id_ex_mem_write  <= 1'b0;
      id_ex_mem_to_reg <= 1'b0;
      id_ex_alu_src    <= 1'b0;
      id_ex_rs         <= '0;
      id_ex_rt         <= '0;
      id_ex_write_reg  <= '0;
      id_ex_rs_data    <= '0;
      id_ex_rt_data    <= '0;
      id_ex_imm        <= '0;
      id_ex_alu_op     <= '0;
      if (load_use_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
    end else begin
      id_ex_valid      <= id_valid;
      id_ex_reg_write  <= id_reg_write  && id_valid;
      id_ex_mem_read   <= id_mem_read   && id_valid;
      id_ex_mem_write  <= id_mem_write  && id_valid;
      id_ex_mem_to_reg <= id_mem_to_reg && id_valid;
      id_ex_alu_src    <= id_alu_src    && id_valid;
      id_ex_rs         <= id_rs;
      id_ex_rt         <= id_rt;
      id_ex_write_reg  <= id_write_reg;
      id_ex_rs_data    <= rs_data_byp;
      id_ex_rt_data    <= rt_data_byp;
      id_ex_imm        <= id_imm;
      id_ex_alu_op     <= id_alu_op;
    end
  end

endmodule

// File: doc/id_ex_hazard_reg.md
Name: id_ex_hazard_reg

Overview:
ID/EX pipeline register with integrated load-use hazard detection and write-back bypass.
- Captures decoded operands and control from ID each cycle.
- Produces the id_ex_rs/id_ex_rt and control values consumed by the EX-stage forwarding unit and operand muxes.
- Inserts bubbles on load-use hazards and branch flushes, and freezes on external memory stalls.
- Drives the PC and IF/ID write enables upstream.

Parameters:
DATA_W, 16, register/operand data width
REG_AW, 3, register address width (8 registers, r0 hardwired zero)
CNT_W, 16, width of saturating stall counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous reset, active-high
id_valid  in  1  ID holds a real instruction
id_rs, id_rt, id_write_reg  in  REG_AW  source and destination addresses from decode
id_uses_rs, id_uses_rt  in  1  instruction actually reads rs/rt
id_rs_data, id_rt_data  in  DATA_W  register file read data
id_imm  in  DATA_W  sign-extended immediate
id_alu_op  in  4  ALU operation code
id_alu_src, id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg  in  1  decode control
wb_reg_write  in  1  WB stage write enable
wb_write_reg  in  REG_AW  WB destination
wb_data  in  DATA_W  WB result
branch_flush  in  1  taken branch resolved in EX; kill ID
ext_stall  in  1  memory busy; freeze pipeline
id_ex_valid, id_ex_reg_write, id_ex_mem_read, id_ex_mem_write, id_ex_mem_to_reg, id_ex_alu_src  out  1  registered control
id_ex_rs, id_ex_rt, id_ex_write_reg  out  REG_AW  registered addresses (to forwarding unit)
id_ex_rs_data, id_ex_rt_data, id_ex_imm  out  DATA_W  registered data
id_ex_alu_op  out  4  registered ALU op
pc_write_en  out  1  combinational; 0 freezes PC
if_id_write_en  out  1  combinational; 0 freezes IF/ID
load_use_stall  out  1  combinational hazard indication
stall_cycles  out  CNT_W  saturating count of load-use bubble cycles

Behaviour:
Reset:
- When rst is high at a clock edge, all registered outputs and stall_cycles go to 0.
- This applies mid-operation and overrides every other input.

Load-use detection (combinational):
- load_use_stall = id_valid & id_ex_valid & id_ex_mem_read & (id_ex_write_reg != 0) & ((id_uses_rs & id_rs == id_ex_write_reg) | (id_uses_rt & id_rt == id_ex_write_reg)).
- load_use_stall is masked to 0 when branch_flush = 1.

Enables (combinational):
- pc_write_en = if_id_write_en = !(ext_stall | load_use_stall).

WB bypass:
- Applies when wb_reg_write & wb_write_reg != 0 & wb_write_reg == id_rs.
- In that case the captured rs_data is wb_data, not id_rs_data. Same rule for rt.
- r0 is never bypassed.

Per-edge update priority:
1. rst: clear.
2. ext_stall: hold all registers; stall_cycles holds. This applies even if branch_flush is high; EX re-presents the flush after the stall.
3. branch_flush: load a bubble.
4. load_use_stall: load a bubble; stall_cycles += 1, saturating at all-ones.
5. Otherwise: capture ID fields. Control bits are ANDed with id_valid; id_ex_valid = id_valid.

Bubble contents:
- valid, reg_write, mem_read, mem_write, mem_to_reg and alu_src are 0.
- Addresses, data, imm and alu_op are 0.
- An invalid ID slot captured normally also has all side-effecting controls at 0.

Timing:
- Latency from ID inputs to id_ex_* is 1 cycle.
- A load-use stall lasts exactly 1 cycle. After the bubble, id_ex_mem_read = 0, so the hazard clears and the held ID instruction is captured next cycle. Its loaded value then arrives via the MEM/WB forwarding path.
- Consecutive independent loads cause no stall.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all id_ex_* = 0, stall_cycles = 0, pc_write_en = 1 once the inputs are quiet.
- Load-use: cycle N ID is a load to r3 (mem_read = 1, write_reg = 3); cycle N+1 ID is an add using rs = 3 -> load_use_stall = 1 and pc_write_en = 0 for 1 cycle, bubble in ID/EX at N+2, add captured at N+3, stall_cycles = 1.
- No false stall: load to r0 followed by a use of r0 -> no stall. Load r3 followed by an instruction with rt = 3 and id_uses_rt = 0 -> no stall.
- WB bypass: wb_reg_write = 1, wb_write_reg = 5, wb_data = 0xBEEF, id_rs = 5, id_rs_data = 0x1111 -> id_ex_rs_data = 0xBEEF next cycle. With wb_write_reg = 0 -> 0x1111.
- Flush vs stall: branch_flush together with a load-use condition -> bubble, load_use_stall = 0, stall_cycles unchanged. branch_flush together with ext_stall -> registers hold their prior values.
- Saturation: preload stall_cycles to 0xFFFE via repeated hazards (or with CNT_W = 2 in a bench variant), then 3 more hazards -> the counter stays at all-ones.
